// File: rtl/arm_mem_pkg.sv
// Shared types and helpers for the unified (code + data) memory controller.
// The top level, unified_mem_ctrl, imports everything from here.
package arm_mem_pkg;

  localparam int DEF_ADDR_W = 6;

  typedef enum logic [2:0] {
    F_ADDR,
    F_DATA,
    EXEC,
    D_DATA,
    COMMIT
  } mem_state_t;

  // Byte address to word index. Bits [1:0] are dropped because only whole words are accessed.
  function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
    return byte_addr >> 2;
  endfunction

endpackage

// File: rtl/unified_mem_ctrl.sv
// Serialises instruction fetch and data access onto one single-port synchronous RAM.
// The core is stalled for every cycle except one commit cycle per instruction.
// Optional feature UNIFIED_MEM_PERF_EN adds the instret_o and stall_cyc_o counters.
module unified_mem_ctrl
  import arm_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       pc_i,
  output logic [31:0]       instr_o,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              stall_o,
  output logic              err_o,
`ifdef UNIFIED_MEM_PERF_EN
  output logic [31:0]       instret_o,
  output logic [31:0]       stall_cyc_o,
`endif
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i
);

  mem_state_t state;
  mem_state_t state_next;

  // Range flag of the access issued in the previous cycle. It decides whether the
  // word returned by the RAM in the following cycle is captured or replaced by zero.
  logic acc_oor;
  logic fetch_oor;
  logic data_oor;
  logic data_access;

  assign fetch_oor   = (pc_i >> (ADDR_W + 2)) != 32'd0;
  assign data_oor    = (addr_i >> (ADDR_W + 2)) != 32'd0;
  assign data_access = mem_write_i || mem_read_i;

  assign stall_o = (state != COMMIT);

  // NOTE: state and datapath registers use non-blocking assignments so that every
  // always_ff block samples the values from before the clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= F_ADDR;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default before the case statement, so
  // no path through it leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_wdata_o = '0;
    unique case (state)
      F_ADDR: begin
        ram_addr_o = ADDR_W'(word_index(pc_i));
        state_next = F_DATA;
      end
      F_DATA: state_next = EXEC;
      EXEC: begin
        if (mem_write_i) begin
          ram_addr_o  = ADDR_W'(word_index(addr_i));
          ram_we_o    = !data_oor;
          ram_wdata_o = wdata_i;
          state_next  = COMMIT;
        end else if (mem_read_i) begin
          ram_addr_o = ADDR_W'(word_index(addr_i));
          state_next = D_DATA;
        end else begin
          state_next = COMMIT;
        end
      end
      D_DATA:  state_next = COMMIT;
      COMMIT:  state_next = F_ADDR;
      default: state_next = F_ADDR;
    endcase
    // The RAM port is idle while reset is held, so a store cut off mid-EXEC stops at once.
    if (!reset) begin
      ram_addr_o  = '0;
      ram_we_o    = 1'b0;
      ram_wdata_o = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_o <= '0;
      rdata_o <= '0;
      err_o   <= 1'b0;
      acc_oor <= 1'b0;
    end else begin
      unique case (state)
        F_ADDR: begin
          acc_oor <= fetch_oor;
          if (fetch_oor) err_o <= 1'b1;
        end
        F_DATA: instr_o <= acc_oor ? 32'd0 : ram_rdata_i;
        EXEC: begin
          if (data_access) begin
            acc_oor <= data_oor;
            if (data_oor) err_o <= 1'b1;
          end
        end
        D_DATA: rdata_o <= acc_oor ? 32'd0 : ram_rdata_i;
        default: ;
      endcase
    end
  end

`ifdef UNIFIED_MEM_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instret_o   <= '0;
      stall_cyc_o <= '0;
    end else if (stall_o) begin
      stall_cyc_o <= stall_cyc_o + 32'd1;
    end else begin
      instret_o <= instret_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Directed bench for unified_mem_ctrl: a behavioural synchronous RAM and a core stand-in
// that drives one instruction at a time and measures its cycle count and RAM writes.
module tb_unified_mem_ctrl;
  import arm_mem_pkg::*;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   pc_i;
  logic [31:0]   instr_o;
  logic          mem_read_i;
  logic          mem_write_i;
  logic [31:0]   addr_i;
  logic [31:0]   wdata_i;
  logic [31:0]   rdata_o;
  logic          stall_o;
  logic          err_o;
  logic [AW-1:0] ram_addr_o;
  logic          ram_we_o;
  logic [31:0]   ram_wdata_o;
  logic [31:0]   ram_rdata_i;
`ifdef UNIFIED_MEM_PERF_EN
  logic [31:0]   instret_o;
  logic [31:0]   stall_cyc_o;
`endif

  logic [31:0] ram [2**AW];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  unified_mem_ctrl #(.ADDR_W(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_i        (pc_i),
    .instr_o     (instr_o),
    .mem_read_i  (mem_read_i),
    .mem_write_i (mem_write_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o),
    .stall_o     (stall_o),
    .err_o       (err_o),
`ifdef UNIFIED_MEM_PERF_EN
    .instret_o   (instret_o),
    .stall_cyc_o (stall_cyc_o),
`endif
    .ram_addr_o  (ram_addr_o),
    .ram_we_o    (ram_we_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_rdata_i (ram_rdata_i)
  );

  always @(posedge clk) begin
    if (ram_we_o) ram[ram_addr_o] <= ram_wdata_o;
    ram_rdata_i <= ram[ram_addr_o];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at the falling edge that opens F_ADDR; returns at the falling edge opening the next F_ADDR.
  task automatic run_instr(input logic [31:0] pc, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int cyc, output int we_cnt,
                           output logic [31:0] we_addr, output logic [31:0] we_data);
    bit done = 1'b0;
    pc_i = pc; mem_read_i = rd; mem_write_i = wr; addr_i = addr; wdata_i = wdata;
    cyc = 0; we_cnt = 0; we_addr = '0; we_data = '0;
    for (int i = 0; i < 10 && !done; i++) begin
      #1;
      cyc++;
      if (ram_we_o) begin
        we_cnt++;
        we_addr = 32'(ram_addr_o);
        we_data = ram_wdata_o;
      end
      if (!stall_o) done = 1'b1;
      @(negedge clk);
    end
    if (!done) check("commit_timeout", 32'(cyc), 32'd5);
    mem_read_i = 1'b0; mem_write_i = 1'b0; addr_i = '0; wdata_i = '0;
  endtask

  int          cyc;
  int          we_cnt;
  logic [31:0] we_addr;
  logic [31:0] we_data;

  initial begin
    for (int i = 0; i < 2**AW; i++) ram[i] = 32'h1000_0000 + 32'(i);
    ram[0] = 32'hE3A0_1005;
    ram[1] = 32'hE580_1000;
    ram[2] = 32'hE590_2000;
    ram[5] = 32'h5555_AAAA;
    reset = 1'b0; pc_i = '0; mem_read_i = 1'b0; mem_write_i = 1'b0; addr_i = '0; wdata_i = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_instr", instr_o, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd1);
    check("rst_we", 32'(ram_we_o), 32'd0);
    check("rst_addr", 32'(ram_addr_o), 32'd0);
    check("rst_wdata", ram_wdata_o, 32'd0);
`ifdef UNIFIED_MEM_PERF_EN
    check("rst_instret", instret_o, 32'd0);
    check("rst_stallcyc", stall_cyc_o, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;

    // First fetch after reset
    run_instr(32'h0, 1'b0, 1'b0, 32'h0, 32'h0, cyc, we_cnt, we_addr, we_data);
    check("t1_cycles", 32'(cyc), 32'd4);
    check("t1_instr", instr_o, 32'hE3A0_1005);
    check("t1_we", 32'(we_cnt), 32'd0);

    // Store, then load it back
    run_instr(32'h4, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, cyc, we_cnt, we_addr, we_data);
    check("t2_st_cycles", 32'(cyc), 32'd4);
    check("t2_st_instr", instr_o, 32'hE580_1000);
    check("t2_st_we_cnt", 32'(we_cnt), 32'd1);
    check("t2_st_addr", we_addr, 32'd4);
    check("t2_st_data", we_data, 32'hDEAD_BEEF);
    run_instr(32'h8, 1'b1, 1'b0, 32'h10, 32'h0, cyc, we_cnt, we_addr, we_data);
    check("t2_ld_cycles", 32'(cyc), 32'd5);
    check("t2_ld_rdata", rdata_o, 32'hDEAD_BEEF);
    check("t2_ld_instr", instr_o, 32'hE590_2000);

    // Back-to-back ALU instructions
    for (int i = 0; i < 3; i++) begin
      run_instr(32'(4 * i), 1'b0, 1'b0, 32'h0, 32'h0, cyc, we_cnt, we_addr, we_data);
      check($sformatf("t3_cycles_%0d", i), 32'(cyc), 32'd4);
      check($sformatf("t3_we_%0d", i), 32'(we_cnt), 32'd0);
    end
    check("t3_instr", instr_o, 32'hE590_2000);
    check("t3_rdata_hold", rdata_o, 32'hDEAD_BEEF);
    check("t3_err", 32'(err_o), 32'd0);

    // Out-of-range load, store and fetch
    run_instr(32'h0, 1'b1, 1'b0, 32'h400, 32'h0, cyc, we_cnt, we_addr, we_data);
    check("t4_ld_cycles", 32'(cyc), 32'd5);
    check("t4_ld_rdata", rdata_o, 32'd0);
    check("t4_ld_err", 32'(err_o), 32'd1);
    run_instr(32'h4, 1'b0, 1'b1, 32'h400, 32'h7777_7777, cyc, we_cnt, we_addr, we_data);
    check("t4_st_we", 32'(we_cnt), 32'd0);
    check("t4_st_ram0", ram[0], 32'hE3A0_1005);
    check("t4_st_err", 32'(err_o), 32'd1);
    run_instr(32'h400, 1'b0, 1'b0, 32'h0, 32'h0, cyc, we_cnt, we_addr, we_data);
    check("t4_if_instr", instr_o, 32'd0);
    check("t4_if_err", 32'(err_o), 32'd1);

    // Read and write together: the write wins, no D_DATA cycle
    run_instr(32'h0, 1'b1, 1'b1, 32'h8, 32'h1234_5678, cyc, we_cnt, we_addr, we_data);
    check("t5_cycles", 32'(cyc), 32'd4);
    check("t5_we_cnt", 32'(we_cnt), 32'd1);
    check("t5_addr", we_addr, 32'd2);
    check("t5_ram2", ram[2], 32'h1234_5678);
    check("t5_rdata_hold", rdata_o, 32'd0);

    // Reset pulsed during EXEC of a store
    pc_i = 32'h0; mem_write_i = 1'b1; addr_i = 32'h14; wdata_i = 32'hCAFE_F00D;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("t6_we_before", 32'(ram_we_o), 32'd1);
    reset = 1'b0;
    #1;
    check("t6_we_async", 32'(ram_we_o), 32'd0);
    check("t6_stall", 32'(stall_o), 32'd1);
    mem_write_i = 1'b0; addr_i = '0; wdata_i = '0;
    @(negedge clk);
    check("t6_ram5", ram[5], 32'h5555_AAAA);
    check("t6_err_clr", 32'(err_o), 32'd0);
`ifdef UNIFIED_MEM_PERF_EN
    check("t6_instret_rst", instret_o, 32'd0);
`endif
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_instr(32'h4, 1'b0, 1'b0, 32'h0, 32'h0, cyc, we_cnt, we_addr, we_data);
      check($sformatf("t6_cycles_%0d", i), 32'(cyc), 32'd4);
    end
    check("t6_instr", instr_o, 32'hE580_1000);
`ifdef UNIFIED_MEM_PERF_EN
    check("t6_instret", instret_o, 32'd3);
    check("t6_stallcyc", stall_cyc_o, 32'd9);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/unified_mem_ctrl.md
Name: unified_mem_ctrl

Overview:
- Sits between the single-cycle ARM core and one single-port synchronous RAM that holds both code and data.
- Serialises each instruction's fetch and optional data access onto the one RAM port.
- Holds the core with a stall until both the instruction word and any load data are ready.
- Releases the core for exactly one commit cycle per instruction.

Parameters:
- ADDR_W, 6: RAM word-address width. Memory holds 2**ADDR_W 32-bit words.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- pc_i  in  32  byte address of the instruction to fetch (core PCNext)
- instr_o  out  32  fetched instruction, registered
- mem_read_i  in  1  core requests a load this instruction
- mem_write_i  in  1  core requests a store this instruction (core MemWrite)
- addr_i  in  32  data byte address (core ALUResult)
- wdata_i  in  32  store data (core WriteData)
- rdata_o  out  32  load data, registered (core ReadData)
- stall_o  out  1  high = core must hold PC and register file
- err_o  out  1  sticky out-of-range access flag
- ram_addr_o  out  ADDR_W  RAM word address
- ram_we_o  out  1  RAM write enable
- ram_wdata_o  out  32  RAM write data
- ram_rdata_i  in  32  RAM read data, valid 1 cycle after address

Behaviour:
- Reset is asynchronous and active-low. On reset:
  - state = F_ADDR
  - instr_o = 0, rdata_o = 0, err_o = 0
  - stall_o = 1, ram_we_o = 0, ram_addr_o = 0, ram_wdata_o = 0
- The FSM advances one state per clk, as follows:
  - F_ADDR: ram_addr_o = pc_i[ADDR_W+1:2]. Next state is F_DATA.
  - F_DATA: instr_o <= ram_rdata_i. Next state is EXEC.
  - EXEC: the core decodes instr_o and drives the mem_*_i, addr_i and wdata_i inputs.
    - If mem_write_i is high: ram_addr_o = addr_i[ADDR_W+1:2], ram_we_o = 1 for this single cycle, ram_wdata_o = wdata_i. Next state is COMMIT.
    - Else if mem_read_i is high: drive the address the same way. Next state is D_DATA.
    - Else: next state is COMMIT.
  - D_DATA: rdata_o <= ram_rdata_i. Next state is COMMIT.
  - COMMIT: stall_o = 0. The core updates PC and the register file. Next state is F_ADDR.
- stall_o = (state != COMMIT). It is decoded combinationally from registered state.
- ram_we_o is high only in EXEC with mem_write_i high, so each store writes exactly once.
- Cycles per instruction:
  - ALU/branch: 4
  - store: 4
  - load: 5
- mem_read_i and mem_write_i both high: the write wins and no read is performed.
- Out of range means addr_i[31:ADDR_W+2] != 0, or pc_i[31:ADDR_W+2] != 0.
  - An out-of-range data store is suppressed (ram_we_o = 0).
  - An out-of-range data load returns rdata_o = 0.
  - An out-of-range fetch returns instr_o = 0.
  - Every out-of-range access sets err_o = 1. err_o clears only on reset.
- Address bits [1:0] are ignored; there is no byte/half access.
- rdata_o holds its value until the next load captures. instr_o holds until the next F_DATA.
- Reset asserted mid-instruction (including during EXEC with a write):
  - ram_we_o drops immediately (async).
  - The FSM restarts at F_ADDR and the instruction is not committed.

Optional Feature:
- Macro: UNIFIED_MEM_PERF_EN
- Defined: adds output instret_o [31:0] and output stall_cyc_o [31:0].
  - instret_o increments on every COMMIT cycle.
  - stall_cyc_o increments on every cycle with stall_o = 1.
  - Both reset to 0 and wrap modulo 2**32.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Package arm_mem_pkg holds:
  - typedef enum mem_state_t {F_ADDR, F_DATA, EXEC, D_DATA, COMMIT}
  - default ADDR_W constant
  - word-index helper function
- No sub-module. The perf counters are small, and the RAM is instantiated outside this block.

Test Plan:
1. Reset held low 3 cycles, then released, pc_i = 0x0, RAM[0] = 0xE3A01005 -> instr_o = 0xE3A01005 from the cycle after F_DATA; stall_o low exactly one cycle, 4 cycles after reset release.
2. Store: EXEC with mem_write_i = 1, addr_i = 0x10, wdata_i = 0xDEADBEEF -> ram_we_o high exactly one cycle with ram_addr_o = 4; a later load from 0x10 gives rdata_o = 0xDEADBEEF in COMMIT; load cycle count is 5.
3. Back-to-back ALU instructions at pc_i = 0, 4, 8 -> stall_o low every 4th cycle; ram_we_o never asserted.
4. Load from addr_i = 0x400 with ADDR_W = 6 -> rdata_o = 0, err_o = 1 and stays 1. Store to 0x400 -> ram_we_o stays 0.
5. mem_read_i = mem_write_i = 1 at addr_i = 0x8 -> single write, state goes EXEC to COMMIT, D_DATA skipped.
6. Reset pulsed during EXEC of a store -> ram_we_o falls in the same cycle, RAM is unchanged, FSM is in F_ADDR. With UNIFIED_MEM_PERF_EN, instret_o = 0 after reset and counts 3 after three instructions.
